// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the radix-2 FFT slice: the butterfly sequencer,
//   the sample data memory and the twiddle ROM all agree on these sizes.
//   Contents:
//     FFT_LOG2N / FFT_N  default transform size (64 points)
//     fft_state_e        sequencer FSM encoding
//     fft_addr_t         sample memory address
//     fft_tw_idx_t       twiddle ROM index (N/2 entries)

package fft_pkg;

    localparam int FFT_LOG2N = 6;
    localparam int FFT_N     = 1 << FFT_LOG2N;

    typedef enum logic [1:0] {
        FST_IDLE  = 2'd0,
        FST_RUN   = 2'd1,
        FST_DRAIN = 2'd2,
        FST_DONE  = 2'd3
    } fft_state_e;

    typedef logic [FFT_LOG2N-1:0] fft_addr_t;
    typedef logic [FFT_LOG2N-2:0] fft_tw_idx_t;

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen
//   Purely combinational butterfly address generator for an in-place
//   radix-2 DIT FFT. Maps (stage, butterfly index k) to the two operand
//   addresses and the twiddle table index.
//   Ports:
//     stage   in   3          current stage 0..LOG2N-1
//     k       in   LOG2N-1    butterfly index within the stage
//     addr_a  out  LOG2N      top operand address
//     addr_b  out  LOG2N      bottom operand address (addr_a + 2^stage)
//     tw_idx  out  LOG2N-1    twiddle index into an N/2-entry table

module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic [2:0]       stage,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx
);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] a_w;
    logic [LOG2N-2:0] tw_w;

    // Split k into a group number and a position inside the group; groups
    // are 2*half samples apart, and bit 'stage' of addr_a is always zero,
    // so addr_b can be formed with an OR instead of an adder.
    always_comb begin
        k_ext = {1'b0, k};
        half  = LOG2N'(1) << stage;
        pos   = k_ext & (half - LOG2N'(1));
        grp   = k_ext >> stage;
        a_w   = (grp << (stage + 3'd1)) | pos;
        // pos < 2^stage, so the shifted result always fits LOG2N-1 bits
        tw_w  = pos[LOG2N-2:0] << (3'(LOG2N - 1) - stage);
    end

    assign addr_a = a_w;
    assign addr_b = a_w | half;
    assign tw_idx = tw_w;

endmodule

// File: rtl/fft_bfly_sequencer.sv
// fft_bfly_sequencer
//   Walks all LOG2N stages of an in-place radix-2 DIT FFT, issuing one
//   butterfly read per cycle and replaying the addresses PIPE_LAT cycles
//   later as the write-back. Between stages it idles for PIPE_LAT cycles
//   so the next stage never reads a location with a pending write.
//   Samples are expected in bit-reversed order in memory.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start                 begin a run (only looked at while idle)
//     hold                  stall read issue this cycle (memory busy)
//     busy                  run in progress
//     done                  one-cycle completion pulse
//     stage                 current stage
//     rd_en, rd_addr_a/b    butterfly read issue and operand addresses
//     tw_idx                twiddle index for the issued butterfly
//     wr_en, wr_addr_a/b    write-back, PIPE_LAT cycles after the read
//     cycle_count           RUN/DRAIN cycle counter, only present when
//                           FFT_SEQ_PERF_CNT_EN is defined

module fft_bfly_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N    = FFT_LOG2N,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic [2:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
`ifdef FFT_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]      cycle_count
`endif
);

    localparam logic [1:0] IDLE  = FST_IDLE;
    localparam logic [1:0] RUN   = FST_RUN;
    localparam logic [1:0] DRAIN = FST_DRAIN;
    localparam logic [1:0] DONE  = FST_DONE;

    localparam int KW = LOG2N - 1;
    localparam int DW = $clog2(PIPE_LAT + 1);

    localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
    localparam logic [2:0]    STAGE_LAST = 3'(LOG2N - 1);

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [DW-1:0]    drain_cnt;

    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_tw;

    logic             dl_en [PIPE_LAT];
    logic [LOG2N-1:0] dl_a  [PIPE_LAT];
    logic [LOG2N-1:0] dl_b  [PIPE_LAT];

    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage  (stage),
        .k      (k),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // Main sequencer. The read port outputs are registered here, so the
    // addresses appear in the same cycle as rd_en. A stage finishes its
    // N/2 issues, then DRAIN waits PIPE_LAT cycles so the last write-back
    // of the stage is out before the next stage's first read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage     <= '0;
            k         <= '0;
            drain_cnt <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        stage <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        rd_en     <= 1'b1;
                        rd_addr_a <= gen_a;
                        rd_addr_b <= gen_b;
                        tw_idx    <= gen_tw;
                        if (k == K_LAST) begin
                            k         <= '0;
                            drain_cnt <= DW'(PIPE_LAT);
                            state     <= DRAIN;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(1)) begin
                        if (stage < STAGE_LAST) begin
                            stage <= stage + 3'd1;
                            state <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-back delay line: it shifts every cycle regardless of hold, so
    // each write trails its read by exactly PIPE_LAT cycles. Reset empties
    // it, dropping any writes still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_en[i] <= 1'b0;
                dl_a[i]  <= '0;
                dl_b[i]  <= '0;
            end
        end else begin
            dl_en[0] <= rd_en;
            dl_a[0]  <= rd_addr_a;
            dl_b[0]  <= rd_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_en[i] <= dl_en[i-1];
                dl_a[i]  <= dl_a[i-1];
                dl_b[i]  <= dl_b[i-1];
            end
        end
    end

    assign wr_en     = dl_en[PIPE_LAT-1];
    assign wr_addr_a = dl_a[PIPE_LAT-1];
    assign wr_addr_b = dl_b[PIPE_LAT-1];

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

`ifdef FFT_SEQ_PERF_CNT_EN
    // Run-length counter: cleared on an accepted start, counts every busy
    // cycle including stalls, then holds its value until the next run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if ((state == IDLE) && start) begin
            cycle_count <= '0;
        end else if (((state == RUN) || (state == DRAIN)) && (cycle_count != 16'hFFFF)) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// tb_fft_bfly_sequencer
//   Self-checking bench for fft_bfly_sequencer (default LOG2N=6, PIPE_LAT=3).
//   Expected read/write events come from a reference model that enumerates
//   butterflies group by group and places them in time from the hold
//   pattern. Define FFT_SEQ_PERF_CNT_EN to also check cycle_count.

module tb_fft_bfly_sequencer;

    localparam int LG   = 6;
    localparam int NN   = 64;
    localparam int PL   = 3;
    localparam int NCYC = 400;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        hold;
    logic        busy;
    logic        done;
    logic [2:0]  stage;
    logic        rd_en;
    logic [5:0]  rd_addr_a;
    logic [5:0]  rd_addr_b;
    logic [4:0]  tw_idx;
    logic        wr_en;
    logic [5:0]  wr_addr_a;
    logic [5:0]  wr_addr_b;
`ifdef FFT_SEQ_PERF_CNT_EN
    logic [15:0] cycle_count;
`endif

    int n_cmp;
    int n_fail;

    bit hold_pat  [0:511];
    bit start_pat [0:511];

    // read event  {cycle[35:20], stage[19:17], a[16:11], b[10:5], tw[4:0]}
    // write event {cycle[27:12], a[11:6], b[5:0]}
    logic [35:0] exp_rd [$];
    logic [35:0] obs_rd [$];
    logic [27:0] exp_wr [$];
    logic [27:0] obs_wr [$];
    int          obs_done [$];
    int          exp_done;
    int          obs_busy;
    logic [15:0] obs_cc;
    logic [15:0] obs_cc_end;

    fft_bfly_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .hold        (hold),
        .busy        (busy),
        .done        (done),
        .stage       (stage),
        .rd_en       (rd_en),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .tw_idx      (tw_idx),
        .wr_en       (wr_en),
        .wr_addr_a   (wr_addr_a),
        .wr_addr_b   (wr_addr_b)
`ifdef FFT_SEQ_PERF_CNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_patterns();
        for (int i = 0; i < 512; i++) begin
            hold_pat[i]  = 1'b0;
            start_pat[i] = 1'b0;
        end
    endtask

    // Reference model: butterflies of stage s pair samples 2^s apart; the
    // groups are visited in order and, inside a group, positions in order.
    // Cycle c is the cycle seen after clock edge c-1 (start sampled at edge 0).
    task automatic build_model();
        int e;
        int a;
        int b;
        int tw;
        e = 1;
        exp_rd.delete();
        exp_wr.delete();
        for (int s = 0; s < LG; s++) begin
            int half;
            half = 1 << s;
            for (int j = 0; j < NN / (2 * half); j++) begin
                for (int p = 0; p < half; p++) begin
                    while (hold_pat[e]) e++;
                    a  = j * 2 * half + p;
                    b  = a + half;
                    tw = p * (NN / (2 * half));
                    exp_rd.push_back({16'(e + 1), 3'(s), 6'(a), 6'(b), 5'(tw)});
                    exp_wr.push_back({16'(e + 1 + PL), 6'(a), 6'(b)});
                    e++;
                end
            end
            e += PL;
        end
        exp_done = e;
    endtask

    // Drives one start pulse plus the stored hold/start patterns and
    // records everything the DUT shows for NCYC cycles.
    task automatic run_capture();
        obs_rd.delete();
        obs_wr.delete();
        obs_done.delete();
        obs_busy = 0;
        obs_cc   = '0;
        @(negedge clk);
        start = 1'b1;
        hold  = 1'b0;
        for (int c = 1; c <= NCYC; c++) begin
            @(negedge clk);
            if (rd_en) obs_rd.push_back({16'(c), stage, rd_addr_a, rd_addr_b, tw_idx});
            if (wr_en) obs_wr.push_back({16'(c), wr_addr_a, wr_addr_b});
            if (done) begin
                obs_done.push_back(c);
`ifdef FFT_SEQ_PERF_CNT_EN
                obs_cc = cycle_count;
`endif
            end
            if (busy) obs_busy++;
            start = start_pat[c];
            hold  = hold_pat[c];
        end
        start = 1'b0;
        hold  = 1'b0;
`ifdef FFT_SEQ_PERF_CNT_EN
        obs_cc_end = cycle_count;
`else
        obs_cc_end = '0;
`endif
    endtask

    task automatic test_reset();
        logic [38:0] outs;
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        repeat (3) @(negedge clk);
        outs = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        hold  = 1'b1;
        repeat (3) @(negedge clk);
        outs = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++;
            $display("[TB] FAIL idle_outputs: got %h expected 0", outs);
        end
        hold = 1'b0;
    endtask

    task automatic test_basic_run();
        clear_patterns();
        build_model();
        run_capture();
        n_cmp++;
        if (obs_rd.size() != 192) begin
            n_fail++;
            $display("[TB] FAIL basic_rd_count: got %0d expected 192", obs_rd.size());
        end
        n_cmp++;
        if (obs_wr.size() != 192) begin
            n_fail++;
            $display("[TB] FAIL basic_wr_count: got %0d expected 192", obs_wr.size());
        end
        n_cmp++;
        if (obs_done.size() != 1 || obs_done[0] != 211) begin
            n_fail++;
            $display("[TB] FAIL basic_done: got %0d pulses first at %0d expected 1 at 211",
                     obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
        end
        n_cmp++;
        if (obs_busy != 210) begin
            n_fail++;
            $display("[TB] FAIL basic_busy_cycles: got %0d expected 210", obs_busy);
        end
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
            n_cmp++;
            if (obs_rd[i] !== exp_rd[i]) begin
                n_fail++;
                $display("[TB] FAIL basic_rd[%0d]: got %h expected %h (cycle,stage,a,b,tw)", i, obs_rd[i], exp_rd[i]);
            end
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            n_cmp++;
            if (obs_wr[i] !== exp_wr[i]) begin
                n_fail++;
                $display("[TB] FAIL basic_wr[%0d]: got %h expected %h (cycle,a,b)", i, obs_wr[i], exp_wr[i]);
            end
        end
        // next stage's first read comes in the cycle right after the
        // previous stage's last write
        for (int s = 0; s < LG - 1; s++) begin
            int last_wr;
            int first_rd;
            last_wr  = (obs_wr.size() >= 192) ? int'(obs_wr[s * 32 + 31][27:12]) : -10;
            first_rd = (obs_rd.size() >= 192) ? int'(obs_rd[(s + 1) * 32][35:20]) : -10;
            n_cmp++;
            if (first_rd != last_wr + 1) begin
                n_fail++;
                $display("[TB] FAIL stage_boundary[%0d]: got first read %0d expected %0d", s, first_rd, last_wr + 1);
            end
        end
    endtask

    task automatic test_hold();
        clear_patterns();
        for (int c = 81; c <= 84; c++) hold_pat[c] = 1'b1;
        build_model();
        run_capture();
        n_cmp++;
        if (obs_done.size() != 1 || obs_done[0] != 215) begin
            n_fail++;
            $display("[TB] FAIL hold_done: got %0d pulses first at %0d expected 1 at 215",
                     obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
        end
        n_cmp++;
        if (obs_rd.size() < 75 || obs_rd[74] !== {16'd86, 3'd2, 6'd18, 6'd22, 5'd16}) begin
            n_fail++;
            $display("[TB] FAIL hold_resume: got %h expected %h",
                     (obs_rd.size() >= 75) ? obs_rd[74] : 36'h0, {16'd86, 3'd2, 6'd18, 6'd22, 5'd16});
        end
        n_cmp++;
        if (obs_rd.size() != exp_rd.size()) begin
            n_fail++;
            $display("[TB] FAIL hold_rd_count: got %0d expected %0d", obs_rd.size(), exp_rd.size());
        end
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
            n_cmp++;
            if (obs_rd[i] !== exp_rd[i]) begin
                n_fail++;
                $display("[TB] FAIL hold_rd[%0d]: got %h expected %h", i, obs_rd[i], exp_rd[i]);
            end
        end
`ifdef FFT_SEQ_PERF_CNT_EN
        n_cmp++;
        if (obs_cc !== 16'd214) begin
            n_fail++;
            $display("[TB] FAIL perf_count_at_done: got %0d expected 214", obs_cc);
        end
        n_cmp++;
        if (obs_cc_end !== 16'd214) begin
            n_fail++;
            $display("[TB] FAIL perf_count_frozen: got %0d expected 214", obs_cc_end);
        end
`endif
    endtask

    task automatic test_start_ignored();
        clear_patterns();
        start_pat[50]  = 1'b1;
        start_pat[211] = 1'b1;
        build_model();
        run_capture();
        n_cmp++;
        if (obs_done.size() != 1 || obs_done[0] != 211) begin
            n_fail++;
            $display("[TB] FAIL start_ignored_done: got %0d pulses first at %0d expected 1 at 211",
                     obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
        end
        n_cmp++;
        if (obs_rd.size() != 192 || obs_wr.size() != 192) begin
            n_fail++;
            $display("[TB] FAIL start_ignored_counts: got %0d reads %0d writes expected 192/192",
                     obs_rd.size(), obs_wr.size());
        end
    endtask

    task automatic test_random_hold();
        for (int it = 0; it < 4; it++) begin
            clear_patterns();
            for (int c = 1; c < 260; c++) hold_pat[c] = ($urandom_range(0, 99) < 15);
            build_model();
            for (int n = 0; n < 3; n++) start_pat[$urandom_range(1, exp_done)] = 1'b1;
            start_pat[exp_done] = 1'b1;
            run_capture();
            n_cmp++;
            if (obs_done.size() != 1 || obs_done[0] != exp_done) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_done: got %0d pulses first at %0d expected 1 at %0d", it,
                         obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, exp_done);
            end
            n_cmp++;
            if (obs_busy != exp_done - 1) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_busy: got %0d expected %0d", it, obs_busy, exp_done - 1);
            end
            n_cmp++;
            if (obs_rd.size() != exp_rd.size() || obs_wr.size() != exp_wr.size()) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_counts: got %0d/%0d expected %0d/%0d", it,
                         obs_rd.size(), obs_wr.size(), exp_rd.size(), exp_wr.size());
            end
            for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
                n_cmp++;
                if (obs_rd[i] !== exp_rd[i]) begin
                    n_fail++;
                    $display("[TB] FAIL rand%0d_rd[%0d]: got %h expected %h", it, i, obs_rd[i], exp_rd[i]);
                end
            end
            for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
                n_cmp++;
                if (obs_wr[i] !== exp_wr[i]) begin
                    n_fail++;
                    $display("[TB] FAIL rand%0d_wr[%0d]: got %h expected %h", it, i, obs_wr[i], exp_wr[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [38:0] outs;
        clear_patterns();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (98) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || rd_en !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrun_active: got busy=%b rd_en=%b expected 1/1", busy, rd_en);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        outs = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset_outputs: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        build_model();
        run_capture();
        n_cmp++;
        if (obs_done.size() != 1 || obs_done[0] != 211) begin
            n_fail++;
            $display("[TB] FAIL after_reset_done: got %0d pulses first at %0d expected 1 at 211",
                     obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
        end
        n_cmp++;
        if (obs_rd.size() != 192 || obs_wr.size() != 192) begin
            n_fail++;
            $display("[TB] FAIL after_reset_counts: got %0d reads %0d writes expected 192/192",
                     obs_rd.size(), obs_wr.size());
        end
        n_cmp++;
        if (obs_rd.size() < 1 || obs_rd[0] !== exp_rd[0]) begin
            n_fail++;
            $display("[TB] FAIL after_reset_first_rd: got %h expected %h",
                     (obs_rd.size() > 0) ? obs_rd[0] : 36'h0, exp_rd[0]);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        hold   = 1'b0;
        test_reset();
        test_basic_run();
        test_hold();
        test_start_ignored();
        test_random_hold();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
